uw_rot_detector: RTL and testbench



---
 rtl/uw_rot_detector.sv | 139 +++++++++++++
 tb/tb_uw_rot_detector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uw_rot_detector.sv
// uw_rot_detector: QPSK unique-word correlator with 4-way rotation estimate and frame flywheel
// Ports: clk, rst_n (async active-low) | in_valid, i_in, q_in: sample stream |
//   best_rot, rot_valid: rotation estimate | lock, uw_hit, frame_start: framing | max_score: last window score
module uw_rot_detector #(
  parameter int UW_LEN = 16,
  parameter logic [2*UW_LEN-1:0] UW_PATTERN = (2*UW_LEN)'(32'hE41B_E41B),
  parameter int THRESH = 14,
  parameter int FRAME_LEN = 256,
  parameter int MISS_MAX = 3,
  parameter int SW = $clog2(UW_LEN+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [15:0]   i_in,
  input  logic [15:0]   q_in,
  output logic [1:0]    best_rot,
  output logic          rot_valid,
  output logic          lock,
  output logic          uw_hit,
  output logic          frame_start,
  output logic [SW-1:0] max_score
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(MISS_MAX+1);
  typedef enum logic {S_SEARCH, S_LOCKED} state_t;
  state_t r_state, w_state;
  logic [2*UW_LEN-1:0] r_win;
  logic [SW-1:0] r_fill;
  logic r_v0, r_v1;
  logic [3:0][SW-1:0] r_sc, w_sc;
  logic [SW-1:0] w_best, r_max, w_max;
  logic [1:0] w_rot, r_best_rot, w_best_rot;
  logic w_hit, w_chk, r_rot_valid, w_rot_valid, r_uw, w_uw, r_fs, w_fs;
  logic [CW-1:0] r_sym, w_sym;
  logic [MW-1:0] r_miss, w_miss;
  wire w_unused = &{1'b0, i_in[14:0], q_in[14:0]};
  function automatic logic [1:0] rot(input logic [1:0] d, input logic [1:0] r);
    return r == 2'd0 ? d : r == 2'd1 ? {d[0], ~d[1]} : r == 2'd2 ? ~d : {~d[0], d[1]};
  endfunction
  // New dibit enters at the top so the oldest symbol ends up at bits [1:0], aligned to pattern symbol 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_win  <= '0;
      r_fill <= '0;
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_sc   <= '0;
    end else begin
      r_win  <= in_valid ? {i_in[15], q_in[15], r_win[2*UW_LEN-1:2]} : r_win;
      r_fill <= (in_valid && r_fill != SW'(UW_LEN)) ? r_fill + SW'(1) : r_fill;
      r_v0   <= in_valid && r_fill >= SW'(UW_LEN-1);
      r_v1   <= r_v0;
      r_sc   <= w_sc;
    end
  always_comb begin
    w_sc = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < UW_LEN; k++)
        w_sc[r] = w_sc[r] + SW'(rot(r_win[2*k +: 2], 2'(r)) == UW_PATTERN[2*k +: 2]);
  end
  // Strict '>' keeps the lowest rotation on ties.
  always_comb begin
    w_best = r_sc[0];
    w_rot  = 2'd0;
    for (int r = 1; r < 4; r++)
      if (r_sc[r] > w_best) begin
        w_best = r_sc[r];
        w_rot  = 2'(r);
      end
  end
  assign w_hit = r_v1 && w_best >= SW'(THRESH);
  assign w_chk = r_sym == CW'(FRAME_LEN-1);
  always_comb begin
    w_state     = r_state;
    w_sym       = r_sym;
    w_miss      = r_miss;
    w_best_rot  = r_best_rot;
    w_rot_valid = r_rot_valid;
    w_uw        = 1'b0;
    w_fs        = 1'b0;
    w_max       = r_max;
    if (r_v1) begin
      w_max = w_best;
      if (r_state == S_SEARCH) begin
        if (w_hit) begin
          w_state     = S_LOCKED;
          w_best_rot  = w_rot;
          w_rot_valid = 1'b1;
          w_uw        = 1'b1;
          w_fs        = 1'b1;
          w_sym       = '0;
          w_miss      = '0;
        end
      end else begin
        w_sym = w_chk ? '0 : r_sym + CW'(1);
        if (w_chk) begin
          w_fs = 1'b1;
          if (w_hit) begin
            w_best_rot = w_rot;
            w_uw       = 1'b1;
            w_miss     = '0;
          end else if (r_miss == MW'(MISS_MAX-1)) begin
            w_state = S_SEARCH;
            w_sym   = '0;
            w_miss  = '0;
          end else
            w_miss = r_miss + MW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_SEARCH;
      r_sym       <= '0;
      r_miss      <= '0;
      r_best_rot  <= 2'd0;
      r_rot_valid <= 1'b0;
      r_uw        <= 1'b0;
      r_fs        <= 1'b0;
      r_max       <= '0;
    end else begin
      r_state     <= w_state;
      r_sym       <= w_sym;
      r_miss      <= w_miss;
      r_best_rot  <= w_best_rot;
      r_rot_valid <= w_rot_valid;
      r_uw        <= w_uw;
      r_fs        <= w_fs;
      r_max       <= w_max;
    end
  assign best_rot    = r_best_rot;
  assign rot_valid   = r_rot_valid;
  assign lock        = r_state == S_LOCKED;
  assign uw_hit      = r_uw;
  assign frame_start = r_fs;
  assign max_score   = r_max;
endmodule

// File: tb/tb_uw_rot_detector.sv
// tb_uw_rot_detector: randomized and directed checks of uw_rot_detector against a quadrant-arithmetic model
module tb_uw_rot_detector;
  localparam int UW = 16, TH = 14, FL = 64, MM = 3;
  localparam logic [31:0] PAT = 32'hE41B_E41B;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [15:0] i_in = '0, q_in = '0;
  logic [1:0] best_rot;
  logic rot_valid, lock, uw_hit, frame_start;
  logic [4:0] max_score;
  always #5 clk = ~clk;
  uw_rot_detector #(.UW_LEN(UW), .UW_PATTERN(PAT), .THRESH(TH), .FRAME_LEN(FL), .MISS_MAX(MM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .best_rot(best_rot), .rot_valid(rot_valid), .lock(lock), .uw_hit(uw_hit),
    .frame_start(frame_start), .max_score(max_score));
  typedef struct packed {logic [1:0] rot; logic rv, lk, hit, fs; logic [4:0] mx;} exp_t;
  exp_t pipe[$];
  int hist[$];
  int pq[UW];
  int checks = 0, errors = 0;
  int m_lock, m_since, m_miss, m_rot, m_rv, m_max;
  // Dibits viewed as QPSK quadrant indices: 00,01,11,10 -> 0,1,2,3; rotation r adds r mod 4.
  function automatic int quad(input logic [1:0] d);
    return d == 2'b00 ? 0 : d == 2'b01 ? 1 : d == 2'b11 ? 2 : 3;
  endfunction
  function automatic logic [1:0] dib(input int q);
    return q == 0 ? 2'b00 : q == 1 ? 2'b01 : q == 2 ? 2'b11 : 2'b10;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic exp_t cur(input bit hit, input bit fs);
    exp_t e;
    e.rot = 2'(m_rot); e.rv = m_rv[0]; e.lk = m_lock[0]; e.hit = hit; e.fs = fs; e.mx = 5'(m_max);
    return e;
  endfunction
  task automatic cmp_all(input exp_t e);
    chk("best_rot", 8'(best_rot), 8'(e.rot));
    chk("rot_valid", 8'(rot_valid), 8'(e.rv));
    chk("lock", 8'(lock), 8'(e.lk));
    chk("uw_hit", 8'(uw_hit), 8'(e.hit));
    chk("frame_start", 8'(frame_start), 8'(e.fs));
    chk("max_score", 8'(max_score), 8'(e.mx));
  endtask
  task automatic model_reset();
    hist.delete();
    m_lock = 0; m_since = 0; m_miss = 0; m_rot = 0; m_rv = 0; m_max = 0;
    pipe.delete();
    pipe.push_back(cur(0, 0));
    pipe.push_back(cur(0, 0));
  endtask
  task automatic model(input bit v, input int qd);
    bit hit = 0, fs = 0, good;
    int best, br, s;
    if (v) begin
      hist.push_back(qd);
      if (hist.size() > UW) void'(hist.pop_front());
    end
    if (v && hist.size() == UW) begin
      best = -1; br = 0;
      for (int r = 0; r < 4; r++) begin
        s = 0;
        for (int k = 0; k < UW; k++) if ((hist[k] + r) % 4 == pq[k]) s++;
        if (s > best) begin best = s; br = r; end
      end
      m_max = best;
      good = best >= TH;
      if (m_lock == 0) begin
        if (good) begin
          m_lock = 1; m_since = 0; m_miss = 0; m_rot = br; m_rv = 1; hit = 1; fs = 1;
        end
      end else begin
        m_since++;
        if (m_since % FL == 0) begin
          fs = 1;
          if (good) begin m_rot = br; hit = 1; m_miss = 0; end
          else begin
            m_miss++;
            if (m_miss == MM) m_lock = 0;
          end
        end
      end
    end
    pipe.push_back(cur(hit, fs));
  endtask
  task automatic step(input bit v, input int qd);
    logic [1:0] d;
    d = dib(qd);
    in_valid = v;
    i_in = d[1] ? 16'hE000 : 16'h2000;
    q_in = d[0] ? 16'hE000 : 16'h2000;
    @(posedge clk);
    model(v, qd);
    #1;
    cmp_all(pipe.pop_front());
  endtask
  task automatic gap(input int maxg);
    repeat ($urandom_range(0, maxg)) step(0, int'($urandom_range(0, 3)));
  endtask
  task automatic noise(input int n, input int maxg);
    repeat (n) begin
      gap(maxg);
      step(1, int'($urandom_range(0, 3)));
    end
  endtask
  // Transmit the UW so that rotation r recovers it; the first nerr symbols are corrupted.
  task automatic send_uw(input int r, input int nerr, input int maxg);
    int q;
    for (int k = 0; k < UW; k++) begin
      q = (pq[k] - r + 4) % 4;
      if (k < nerr) q = (q + 1) % 4;
      gap(maxg);
      step(1, q);
    end
  endtask
  task automatic expect_after(input bit hit, input int rot, input int score, input bit lk);
    step(1, int'($urandom_range(0, 3)));
    step(1, int'($urandom_range(0, 3)));
    chk("dir_uw_hit", 8'(uw_hit), 8'(hit));
    chk("dir_max_score", 8'(max_score), 8'(score));
    chk("dir_lock", 8'(lock), 8'(lk));
    if (hit) begin
      chk("dir_best_rot", 8'(best_rot), 8'(rot));
      chk("dir_frame_start", 8'(frame_start), 8'd1);
    end
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_lock", 8'(lock), 8'd0);
    chk("rst_best_rot", 8'(best_rot), 8'd0);
    chk("rst_rot_valid", 8'(rot_valid), 8'd0);
    chk("rst_max_score", 8'(max_score), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uw_hit", 8'(uw_hit), 8'd0);
    chk("rst_frame_start", 8'(frame_start), 8'd0);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] pat;
    pat = PAT;
    for (int k = 0; k < UW; k++) pq[k] = quad(pat[2*k +: 2]);
    do_reset();
    noise(15, 0);
    chk("fill_max_score", 8'(max_score), 8'd0);
    noise(30, 0);
    send_uw(0, 0, 0);
    expect_after(1, 0, 16, 1);
    do_reset();
    noise(20, 0);
    send_uw(2, 0, 0);
    expect_after(1, 2, 16, 1);
    do_reset();
    noise(20, 0);
    send_uw(1, 0, 0);
    expect_after(1, 1, 16, 1);
    do_reset();
    noise(20, 0);
    send_uw(3, 0, 0);
    expect_after(1, 3, 16, 1);
    do_reset();
    noise(20, 0);
    send_uw(2, 3, 0);
    expect_after(0, 0, 13, 0);
    noise(10, 0);
    send_uw(2, 2, 0);
    expect_after(1, 2, 14, 1);
    for (int f = 0; f < 3; f++) begin
      noise(FL - UW - 2, 0);
      send_uw(f == 1 ? 1 : 0, 0, 0);
      expect_after(1, f == 1 ? 1 : 0, 16, 1);
    end
    noise(FL - UW - 2 - 10, 0);
    send_uw(0, 0, 0);
    step(1, int'($urandom_range(0, 3)));
    step(1, int'($urandom_range(0, 3)));
    chk("early_uw_hit", 8'(uw_hit), 8'd0);
    noise(8, 0);
    noise(2 * FL, 0);
    noise(2, 0);
    chk("drop_lock", 8'(lock), 8'd0);
    chk("drop_best_rot", 8'(best_rot), 8'd0);
    chk("drop_rot_valid", 8'(rot_valid), 8'd1);
    do_reset();
    noise(25, 2);
    send_uw(3, 0, 2);
    for (int f = 0; f < 2; f++) begin
      noise(FL - UW, 2);
      send_uw(f, 1, 2);
    end
    noise(20, 2);
    do_reset();
    noise(40, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
